// File: rtl/counter_nested_if.sv
// Bus bundle for counter_nested: enable, per-dimension limits, indices and flags.
// With COUNTER_NESTED_STEP_EN defined, the bundle also carries the dimension-0 step.
interface counter_nested_if #(
  parameter int N = 10,
  parameter int D = 3
);
  logic           en;
  logic [D*N-1:0] max_i;
  logic [D*N-1:0] y;
  logic [D-1:0]   tc;
  logic           last;
  logic           wrap;
`ifdef COUNTER_NESTED_STEP_EN
  logic [N-1:0]   step;

  modport master (output en, max_i, step, input y, tc, last, wrap);
  modport slave  (input en, max_i, step, output y, tc, last, wrap);
`else
  modport master (output en, max_i, input y, tc, last, wrap);
  modport slave  (input en, max_i, output y, tc, last, wrap);
`endif
endinterface

// File: rtl/counter_nested.sv
// D-dimensional nested counter with per-dimension inclusive limits and a full-nest wrap pulse.
// Optional macro COUNTER_NESTED_STEP_EN adds a programmable dimension-0 increment.
module counter_nested #(
  parameter int N = 10,
  parameter int D = 3
) (
  input  logic            clk,
  input  logic            reset,
  counter_nested_if.slave bus
);

  logic [D*N-1:0] y_q, y_d;
  logic           wrap_q, wrap_d;
  logic [D-1:0]   atMax;
  logic [D-1:0]   tc;
  logic [N-1:0]   next0;
`ifdef COUNTER_NESTED_STEP_EN
  logic [N-1:0]   inc;
  logic [N:0]     sum0;
`endif

  // An index above its limit (e.g. after max_i shrinks) is treated as terminal.
  always_comb begin
    atMax = '0;
    for (int d = 0; d < D; d++) begin
      atMax[d] = (y_q[d*N +: N] >= bus.max_i[d*N +: N]);
    end
`ifdef COUNTER_NESTED_STEP_EN
    inc   = (bus.step == '0) ? N'(1) : bus.step;
    sum0  = {1'b0, y_q[N-1:0]} + {1'b0, inc};
    next0 = sum0[N-1:0];
    atMax[0] = atMax[0] | (sum0 > {1'b0, bus.max_i[N-1:0]});
`else
    next0 = y_q[N-1:0] + N'(1);
`endif
    tc    = '0;
    tc[0] = atMax[0];
    for (int d = 1; d < D; d++) begin
      tc[d] = tc[d-1] & atMax[d];
    end
  end

  always_comb begin
    y_d    = y_q;
    wrap_d = 1'b0;
    if (bus.en) begin
      y_d[N-1:0] = atMax[0] ? '0 : next0;
      for (int d = 1; d < D; d++) begin
        if (tc[d]) begin
          y_d[d*N +: N] = '0;
        end else if (tc[d-1]) begin
          y_d[d*N +: N] = y_q[d*N +: N] + N'(1);
        end
      end
      wrap_d = tc[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.tc   = tc;
  assign bus.last = tc[D-1];
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_counter_nested.sv
// Directed bench for counter_nested: a 3-deep nest (N=4) and a single-dimension counter (N=4).
// Step tests run only when COUNTER_NESTED_STEP_EN is defined.
module tb_counter_nested;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  counter_nested_if #(.N(4), .D(3)) ifA ();
  counter_nested_if #(.N(4), .D(1)) ifB ();

  counter_nested #(.N(4), .D(3)) dutA (.clk(clk), .reset(reset), .bus(ifA));
  counter_nested #(.N(4), .D(1)) dutB (.clk(clk), .reset(reset), .bus(ifB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic        enSeq [4];
    logic [31:0] expSeq[4];
    logic [31:0] expY;
    checks = 0;
    errors = 0;
    enSeq  = '{1'b1, 1'b0, 1'b0, 1'b1};
    expSeq = '{32'd3, 32'd3, 32'd3, 32'd4};

    reset     = 1'b1;
    ifA.en    = 1'b1;
    ifA.max_i = 12'h321;
    ifB.en    = 1'b0;
    ifB.max_i = 4'hF;
`ifdef COUNTER_NESTED_STEP_EN
    ifA.step  = 4'd1;
    ifB.step  = 4'd1;
`endif
    applyStimulus(2);
    checkOutput("rst_yA", ifA.y, 32'h0);
    checkOutput("rst_wrapA", ifA.wrap, 32'h0);
    checkOutput("rst_tcA", ifA.tc, 32'h0);
    checkOutput("rst_yB", ifB.y, 32'h0);

    ifA.max_i = 12'h000;
    #1;
    checkOutput("rst_tc_zero_max", ifA.tc, 32'h7);
    checkOutput("rst_last_zero_max", ifA.last, 32'h1);
    ifA.max_i = 12'h321;
    #1;
    reset = 1'b0;

    // Mixed radix (2,3,4): dim0 = k%2, dim1 = (k/2)%3, dim2 = (k/6)%4.
    for (int k = 1; k <= 24; k++) begin
      applyStimulus(1);
      expY = (((k / 6) % 4) << 8) | (((k / 2) % 3) << 4) | (k % 2);
      checkOutput("nest_y", ifA.y, expY);
      checkOutput("nest_wrap", ifA.wrap, (k == 24) ? 32'h1 : 32'h0);
      if (k == 1)  checkOutput("nest_tc_k1", ifA.tc, 32'h1);
      if (k == 23) checkOutput("nest_last_k23", ifA.last, 32'h1);
    end
    applyStimulus(1);
    checkOutput("nest_after_y", ifA.y, 32'h001);
    checkOutput("nest_after_wrap", ifA.wrap, 32'h0);

    applyStimulus(22);
    checkOutput("pre_rst_y", ifA.y, 32'h321);
    checkOutput("pre_rst_last", ifA.last, 32'h1);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("rst_last_y", ifA.y, 32'h0);
    checkOutput("rst_last_wrap", ifA.wrap, 32'h0);
    reset  = 1'b0;
    ifA.en = 1'b0;
    applyStimulus(1);
    checkOutput("rst_last_wrap2", ifA.wrap, 32'h0);
    checkOutput("rst_last_y2", ifA.y, 32'h0);

    ifB.en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1);
      checkOutput("full_y", ifB.y, 32'(i % 16));
      checkOutput("full_wrap", ifB.wrap, (i == 16) ? 32'h1 : 32'h0);
      checkOutput("full_tc", ifB.tc, (i == 15) ? 32'h1 : 32'h0);
    end
    ifB.en = 1'b0;
    applyStimulus(1);
    checkOutput("full_wrap_clear", ifB.wrap, 32'h0);

    ifB.max_i = 4'd5;
    ifB.en    = 1'b1;
    applyStimulus(2);
    checkOutput("hold_start", ifB.y, 32'd2);
    for (int i = 0; i < 4; i++) begin
      ifB.en = enSeq[i];
      applyStimulus(1);
      checkOutput("hold_y", ifB.y, expSeq[i]);
      checkOutput("hold_wrap", ifB.wrap, 32'h0);
    end

    ifB.max_i = 4'd0;
    #1;
    checkOutput("zero_max_tc", ifB.tc, 32'h1);
    checkOutput("zero_max_last", ifB.last, 32'h1);
    applyStimulus(1);
    checkOutput("zero_max_y1", ifB.y, 32'h0);
    checkOutput("zero_max_wrap1", ifB.wrap, 32'h1);
    applyStimulus(1);
    checkOutput("zero_max_y2", ifB.y, 32'h0);
    checkOutput("zero_max_wrap2", ifB.wrap, 32'h1);
    ifB.en = 1'b0;
    applyStimulus(1);
    checkOutput("zero_max_wrap3", ifB.wrap, 32'h0);

    ifA.max_i = 12'h33F;
    ifA.en    = 1'b1;
    applyStimulus(7);
    checkOutput("shrink_y7", ifA.y, 32'h007);
    checkOutput("shrink_tc_before", ifA.tc, 32'h0);
    ifA.max_i = 12'h334;
    #1;
    checkOutput("shrink_tc_after", ifA.tc, 32'h1);
    applyStimulus(1);
    checkOutput("shrink_y", ifA.y, 32'h010);
    checkOutput("shrink_wrap", ifA.wrap, 32'h0);

`ifdef COUNTER_NESTED_STEP_EN
    ifA.en = 1'b0;
    reset  = 1'b1;
    applyStimulus(1);
    reset     = 1'b0;
    ifA.max_i = 12'h33A;
    ifA.step  = 4'd3;
    ifA.en    = 1'b1;
    expSeq    = '{32'h003, 32'h006, 32'h009, 32'h010};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("step_y", ifA.y, expSeq[i]);
    end
    ifA.step = 4'd0;
    applyStimulus(1);
    checkOutput("step_zero_y", ifA.y, 32'h011);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_nested.md
COUNTER_NESTED -- requirements
Module: counter_nested

Interface
REQ-001 SHALL have parameter N, default 10, bit width of each dimension's index.
REQ-002 SHALL have parameter D, default 3, number of nested dimensions (1..8); dimension 0 is innermost.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  advance counter by one step in this cycle.
REQ-006 SHALL have port max_i  input  D*N  per-dimension inclusive terminal value; dimension d at bits [d*N +: N].
REQ-007 SHALL have port y  output  D*N  registered per-dimension indices, same packing as max_i.
REQ-008 SHALL have port tc  output  D  per-dimension terminal flag.
REQ-009 SHALL have port last  output  1  all dimensions at terminal; equals tc[D-1].
REQ-010 SHALL have port wrap  output  1  registered one-cycle pulse marking a full-nest wrap.

Function
REQ-011 SHALL define at_max[d] = (y[d] >= max_i[d]), unsigned compare, combinational from current y and max_i.
REQ-012 SHALL drive tc[d] = at_max[0] AND ... AND at_max[d], combinational, zero cycle latency from y/max_i.
REQ-013 SHALL, when en=0, hold y and drive wrap to 0 on the next edge.
REQ-014 SHALL, when en=1, set y[0] to 0 if at_max[0], else y[0]+step (step per REQ-026/027).
REQ-015 SHALL, when en=1 and d>0, set y[d] to 0 if tc[d], else y[d]+1 if tc[d-1], else hold y[d].
REQ-016 SHALL, when en=1 and last=1, set all y to 0 and register wrap=1 for exactly the following cycle.
REQ-017 SHALL keep index arithmetic modulo 2^N; max_i[d]=2^N-1 yields a full wrap-around count of 2^N values.
REQ-018 SHALL treat max_i[d]=0 as a dimension fixed at 0 that is always terminal.
REQ-019 SHALL allow max_i to change at any cycle; an index already above a new max counts as terminal and wraps to 0 on the next enabled step.
REQ-020 SHALL produce exactly (max0+1)*...*(maxD-1 + 1) enabled steps per full nest with step fixed at 1.
REQ-021 SHALL sustain one step per cycle with no bubbles under continuous en.

Reset
REQ-022 SHALL, on reset=1 at a rising edge, set all y to 0 and wrap to 0, regardless of en.
REQ-023 SHALL give reset priority over en and over an in-progress wrap; the wrap pulse SHALL be suppressed.
REQ-024 SHALL resume counting from all-zero on the first enabled edge after reset deasserts.
REQ-025 SHALL present tc/last after reset per REQ-011/012 (e.g. all high if max_i is all zero).

Configuration
REQ-026 SHALL, with macro COUNTER_NESTED_STEP_EN defined, add port step  input  N  dimension-0 increment; at_max[0] becomes (y[0] >= max_i[0]) OR (y[0]+step > max_i[0]) computed at N+1 bits; step=0 SHALL be treated as 1.
REQ-027 SHALL, without COUNTER_NESTED_STEP_EN, omit port step and use a fixed increment of 1 with the REQ-011 compare.

Verification
REQ-028 SHALL cover: D=3, N=4, max_i={1,2,3}, en=1 for 24 cycles -> y sequences (0,0,0)..(3,2,1) in order, wrap=1 on cycle 25 only, y=(0,0,0).
REQ-029 SHALL cover: max0=15, N=4, D=1, en=1 -> y0 runs 0..15, tc[0]=1 at 15, wraps to 0, wrap pulses.
REQ-030 SHALL cover: en toggled 1,0,0,1 at y0=2, max0=5 -> y0 holds 3 for two cycles, then 4; no wrap.
REQ-031 SHALL cover: y0=7, max0 changed to 4, en=1 -> y0=0, y1 increments on the same edge.
REQ-032 SHALL cover: reset=1 with en=1 and last=1 -> y all 0, wrap stays 0 next cycle.
REQ-033 SHALL cover (COUNTER_NESTED_STEP_EN): step=3, max0=10 -> y0 0,3,6,9,0; y1 increments on the 9->0 edge.
